multicycle_control_fsm: RTL and testbench
=========================================

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 Parameter OPCODE_W, default 6, opcode field width.
REQ-002 Parameter ALUOP_W, default 3, ALU operation code width; values below are right-aligned and zero-extended.
REQ-003 Parameter CNT_W, default 32, retired-instruction counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 opcode  input  OPCODE_W  opcode of the instruction register; sampled in DECODE only.
REQ-007 mem_ready  input  1  memory completion; a memory state may exit only on the edge where it is 1.
REQ-008 pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath controls.
REQ-009 alu_src_b  output  2  00=regB, 01=const 4, 10=sign-extended immediate, 11=shifted immediate.
REQ-010 pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-011 alu_op  output  ALUOP_W  add=000, addi=001, and=010, slt=011, R-type=100, sub/beq=101, or=111.
REQ-012 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-013 state  output  4  current state encoding, for debug.
REQ-014 retired  output  CNT_W  count of completed instructions.

Function
REQ-015 Outputs are Moore-decoded from the state register; the only exception is gating by mem_ready (REQ-017).
REQ-016 States: FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP.
REQ-017 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00, ir_write=pc_write=mem_ready. The FSM holds in FETCH while mem_ready=0 and moves to DECODE when mem_ready=1.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_op=000. Next state by opcode: 000000 to EXEC_R; 100011 or 101011 to MEMADDR; 001000, 001100, 001010 or 001101 to EXEC_I; 000100 to BRANCH; 000010 to JUMP; any other value to FETCH with illegal_op=1 in the DECODE cycle.
REQ-019 MEMADDR: alu_src_a=1, alu_src_b=10, alu_op=000. Next state is MEMREAD for LW and MEMWRITE for SW; the opcode is latched in DECODE.
REQ-020 MEMREAD: mem_read=1, iord=1. The FSM holds while mem_ready=0, then goes to MEMWB.
REQ-021 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state is FETCH.
REQ-022 MEMWRITE: mem_write=1, iord=1. The FSM holds while mem_ready=0, then goes to FETCH.
REQ-023 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=100. Next state is WB_R, where reg_write=1 and reg_dst=1; after WB_R the FSM returns to FETCH.
REQ-024 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op per latched opcode (ADDI 001, ANDI 010, SLTI 011, ORI 111). Next state is WB_I, where reg_write=1 and reg_dst=0; after WB_I the FSM returns to FETCH.
REQ-025 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=101, pc_write_cond=1, pc_source=01. Next state is FETCH.
REQ-026 JUMP: pc_write=1, pc_source=10. Next state is FETCH.
REQ-027 Every output not listed for a state is 0 in that state.
REQ-028 retired increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, WB_R, WB_I, BRANCH or JUMP. It wraps modulo 2^CNT_W and does not increment on an illegal opcode.
REQ-029 The opcode latch is written only in DECODE; changes to opcode in other states have no effect.

Reset
REQ-030 When rst_n=0 at a rising edge, the next state is FETCH, retired=0 and the opcode latch=0, regardless of current state or mem_ready.
REQ-031 While in reset, outputs equal the FETCH decode, with illegal_op=0 and mem_write=0; a store interrupted by reset is dropped.

Structure
REQ-032 The package multicycle_pkg holds the state enum, the opcode constants and the ALU-op constants, shared with the datapath.
REQ-033 One sub-module, alu_op_decode, maps the latched opcode to alu_op for EXEC_I; all other logic is in the FSM module.

Verification
REQ-034 Reset, then opcode=000000 with mem_ready=1: states FETCH, DECODE, EXEC_R, WB_R; reg_write=reg_dst=1 in the 4th cycle; retired goes from 0 to 1.
REQ-035 LW (100011) with mem_ready=0 for 3 cycles in MEMREAD: mem_read=iord=1 is held for 4 cycles, then MEMWB with mem_to_reg=1; total 8 cycles.
REQ-036 BEQ (000100): the BRANCH cycle shows pc_write_cond=1, alu_op=101, pc_source=01, alu_src_b=00; the instruction takes 3 cycles.
REQ-037 opcode=111111: illegal_op=1 for exactly one cycle, reg_write and mem_write never assert, next state is FETCH, retired is unchanged.
REQ-038 rst_n=0 during MEMWRITE with mem_ready=0: the next cycle is FETCH with mem_write=0 and retired=0.
REQ-039 With CNT_W=4, 16 consecutive J (000010) instructions: retired wraps from 15 to 0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle control path: state enum, opcodes,
// ALU operation codes and datapath mux selects.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADDR  = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC_R   = 4'd6,
        WB_R     = 4'd7,
        EXEC_I   = 4'd8,
        WB_I     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_ADDI  = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_SLT   = 3'b011;
    localparam logic [2:0] ALU_RTYPE = 3'b100;
    localparam logic [2:0] ALU_SUB   = 3'b101;
    localparam logic [2:0] ALU_OR    = 3'b111;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIFT = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_op_decode.sv
// Maps the latched immediate-class opcode to the ALU operation used in EXEC_I.
module alu_op_decode import multicycle_pkg::*; #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic [ALUOP_W-1:0]  alu_op
);

    logic [2:0] code;

    always_comb begin
        code = ALU_ADD;
        if (opcode == OPCODE_W'(OP_ADDI))      code = ALU_ADDI;
        else if (opcode == OPCODE_W'(OP_ANDI)) code = ALU_AND;
        else if (opcode == OPCODE_W'(OP_SLTI)) code = ALU_SLT;
        else if (opcode == OPCODE_W'(OP_ORI))  code = ALU_OR;
    end

    assign alu_op = ALUOP_W'(code);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-style control unit: state register, opcode latch, retired
// counter and Moore output decode (FETCH write enables gated by mem_ready).
module multicycle_control_fsm import multicycle_pkg::*; #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_source,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                illegal_op,
    output logic [3:0]          state,
    output logic [CNT_W-1:0]    retired
);

    state_t              state_q;
    state_t              next_state;
    state_t              dec_state;
    logic [OPCODE_W-1:0] op_q;
    logic [ALUOP_W-1:0]  imm_alu_op;
    logic                is_rtype, is_mem, is_imm, is_beq, is_j;
    logic                retire;

    alu_op_decode #(
        .OPCODE_W (OPCODE_W),
        .ALUOP_W  (ALUOP_W)
    ) u_alu_op_decode (
        .opcode (op_q),
        .alu_op (imm_alu_op)
    );

    assign is_rtype = (opcode == OPCODE_W'(OP_RTYPE));
    assign is_mem   = (opcode == OPCODE_W'(OP_LW))   || (opcode == OPCODE_W'(OP_SW));
    assign is_imm   = (opcode == OPCODE_W'(OP_ADDI)) || (opcode == OPCODE_W'(OP_ANDI)) ||
                      (opcode == OPCODE_W'(OP_SLTI)) || (opcode == OPCODE_W'(OP_ORI));
    assign is_beq   = (opcode == OPCODE_W'(OP_BEQ));
    assign is_j     = (opcode == OPCODE_W'(OP_J));

    always_comb begin
        next_state = state_q;
        case (state_q)
            FETCH:    if (mem_ready) next_state = DECODE;
            DECODE: begin
                if (is_rtype)    next_state = EXEC_R;
                else if (is_mem) next_state = MEMADDR;
                else if (is_imm) next_state = EXEC_I;
                else if (is_beq) next_state = BRANCH;
                else if (is_j)   next_state = JUMP;
                else             next_state = FETCH;
            end
            // Only LW and SW reach MEMADDR, so anything not LW is a store.
            MEMADDR:  next_state = (op_q == OPCODE_W'(OP_LW)) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (mem_ready) next_state = MEMWB;
            MEMWRITE: if (mem_ready) next_state = FETCH;
            EXEC_R:   next_state = WB_R;
            EXEC_I:   next_state = WB_I;
            MEMWB, WB_R, WB_I, BRANCH, JUMP: next_state = FETCH;
            default:  next_state = FETCH;
        endcase
    end

    assign retire = (next_state == FETCH) &&
                    (state_q inside {MEMWB, MEMWRITE, WB_R, WB_I, BRANCH, JUMP});

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
        if (!rst_n) begin
            state_q <= FETCH;
            op_q    <= '0;
            retired <= '0;
        end else begin
            state_q <= next_state;
            if (state_q == DECODE) op_q <= opcode;
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

    // While reset is held the outputs show FETCH, whatever the register holds.
    assign dec_state  = rst_n ? state_q : FETCH;
    assign state      = dec_state;
    assign illegal_op = rst_n && (state_q == DECODE) &&
                        !(is_rtype || is_mem || is_imm || is_beq || is_j);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REGB;
        pc_source     = PCSRC_ALU;
        alu_op        = '0;
        case (dec_state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALUOP_W'(ALU_ADD);
                pc_source = PCSRC_ALU;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = SRCB_SHIFT;
                alu_op    = ALUOP_W'(ALU_ADD);
            end
            MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_W'(ALU_ADD);
            end
            MEMREAD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REGB;
                alu_op    = ALUOP_W'(ALU_RTYPE);
            end
            WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = imm_alu_op;
            end
            WB_I:   reg_write = 1'b1;
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_REGB;
                alu_op        = ALUOP_W'(ALU_SUB);
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: per-cycle vector table with a scoreboard queue, plus
// hand-driven LW wait-state and illegal-opcode sequences.
module tb_multicycle_control_fsm;
    import multicycle_pkg::*;

    typedef struct packed {
        logic       pc_write, pc_write_cond, iord, mem_read, mem_write;
        logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       illegal_op;
    } ctl_t;

    typedef struct {
        logic        rn;
        logic [5:0]  op;
        logic        mr;
        state_t      st;
        logic [31:0] ret;
        logic [2:0]  iop;
        logic        ill;
    } vec_t;

    typedef struct {
        int          idx;
        state_t      st;
        ctl_t        ctl;
        logic [31:0] ret;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;

    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, pc_source;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic [31:0] retired;

    logic        pc_write4, pc_write_cond4, iord4, mem_read4, mem_write4, ir_write4;
    logic        mem_to_reg4, reg_dst4, reg_write4, alu_src_a4, illegal_op4;
    logic [1:0]  alu_src_b4, pc_source4;
    logic [2:0]  alu_op4;
    logic [3:0]  state4;
    logic [3:0]  retired4;

    ctl_t act, act4;
    assign act  = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                   reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal_op};
    assign act4 = {pc_write4, pc_write_cond4, iord4, mem_read4, mem_write4, ir_write4, mem_to_reg4,
                   reg_dst4, reg_write4, alu_src_a4, alu_src_b4, pc_source4, alu_op4, illegal_op4};

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_source(pc_source), .alu_op(alu_op), .illegal_op(illegal_op), .state(state),
        .retired(retired)
    );

    multicycle_control_fsm #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write4), .pc_write_cond(pc_write_cond4), .iord(iord4), .mem_read(mem_read4),
        .mem_write(mem_write4), .ir_write(ir_write4), .mem_to_reg(mem_to_reg4), .reg_dst(reg_dst4),
        .reg_write(reg_write4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4),
        .pc_source(pc_source4), .alu_op(alu_op4), .illegal_op(illegal_op4), .state(state4),
        .retired(retired4)
    );

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[128];
    int   nvec = 0;
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic add(input logic rn, input logic [5:0] op, input logic mr, input state_t st,
                       input logic [31:0] ret, input logic [2:0] iop = 3'b000,
                       input logic ill = 1'b0);
        vecs[nvec] = '{rn: rn, op: op, mr: mr, st: st, ret: ret, iop: iop, ill: ill};
        nvec++;
    endtask

    // Expected control word for each state, written from the control table.
    function automatic ctl_t ref_ctl(input state_t st, input logic mr, input logic [2:0] iop,
                                     input logic ill);
        ctl_t c = '0;
        case (st)
            FETCH:    begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
            DECODE:   begin c.alu_src_b = 2'b11; c.illegal_op = ill; end
            MEMADDR:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            MEMREAD:  begin c.mem_read = 1; c.iord = 1; end
            MEMWB:    begin c.reg_write = 1; c.mem_to_reg = 1; end
            MEMWRITE: begin c.mem_write = 1; c.iord = 1; end
            EXEC_R:   begin c.alu_src_a = 1; c.alu_op = 3'b100; end
            WB_R:     begin c.reg_write = 1; c.reg_dst = 1; end
            EXEC_I:   begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = iop; end
            WB_I:     c.reg_write = 1;
            BRANCH:   begin c.alu_src_a = 1; c.alu_op = 3'b101; c.pc_write_cond = 1; c.pc_source = 2'b01; end
            JUMP:     begin c.pc_write = 1; c.pc_source = 2'b10; end
            default:  ;
        endcase
        return c;
    endfunction

    task automatic add_imm(input logic [5:0] op, input logic [2:0] iop, input logic [31:0] ret);
        add(1, 6'h00, 1, FETCH, ret);
        add(1, op, 1, DECODE, ret);
        add(1, 6'h00, 1, EXEC_I, ret, iop);
        add(1, 6'h00, 1, WB_I, ret);
    endtask

    initial begin
        exp_t e;
        int   cyc, mrd, waits, ill_cnt, bad;
        logic done;

        // Reset held; row 0 re-checks reset state.
        add(0, 6'h00, 0, FETCH, 0);
        add(1, 6'h00, 0, FETCH, 0);
        // R-type
        add(1, 6'h00, 1, FETCH, 0);
        add(1, 6'h00, 1, DECODE, 0);
        add(1, 6'h00, 1, EXEC_R, 0);
        add(1, 6'h00, 1, WB_R, 0);
        // LW with three wait cycles; opcode changed in MEMADDR must be ignored
        add(1, 6'h00, 1, FETCH, 1);
        add(1, 6'b100011, 0, DECODE, 1);
        add(1, 6'b101011, 0, MEMADDR, 1);
        add(1, 6'h00, 0, MEMREAD, 1);
        add(1, 6'h00, 0, MEMREAD, 1);
        add(1, 6'h00, 0, MEMREAD, 1);
        add(1, 6'h00, 1, MEMREAD, 1);
        add(1, 6'h00, 1, MEMWB, 1);
        // BEQ
        add(1, 6'h00, 1, FETCH, 2);
        add(1, 6'b000100, 1, DECODE, 2);
        add(1, 6'h00, 1, BRANCH, 2);
        // Illegal opcode: back to FETCH, count unchanged
        add(1, 6'h00, 1, FETCH, 3);
        add(1, 6'b111111, 1, DECODE, 3, 3'b000, 1'b1);
        // Immediate ops, opcode cleared during EXEC_I to prove the latch holds
        add_imm(6'b001101, 3'b111, 3);
        add_imm(6'b001000, 3'b001, 4);
        add_imm(6'b001100, 3'b010, 5);
        add_imm(6'b001010, 3'b011, 6);
        // SW with one wait cycle
        add(1, 6'h00, 1, FETCH, 7);
        add(1, 6'b101011, 1, DECODE, 7);
        add(1, 6'h00, 0, MEMADDR, 7);
        add(1, 6'h00, 0, MEMWRITE, 7);
        add(1, 6'h00, 1, MEMWRITE, 7);
        // SW interrupted by reset in MEMWRITE
        add(1, 6'h00, 1, FETCH, 8);
        add(1, 6'b101011, 1, DECODE, 8);
        add(1, 6'h00, 0, MEMADDR, 8);
        add(1, 6'h00, 0, MEMWRITE, 8);
        add(0, 6'h00, 0, FETCH, 8);
        // 16 jumps from a cleared counter: the 4-bit copy wraps 15 -> 0
        for (int k = 0; k < 16; k++) begin
            add(1, 6'h00, 1, FETCH, k);
            add(1, 6'b000010, 1, DECODE, k);
            add(1, 6'h00, 1, JUMP, k);
        end
        add(1, 6'h00, 0, FETCH, 16);

        rst_n = 0; opcode = '0; mem_ready = 0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            rst_n = vecs[i].rn; opcode = vecs[i].op; mem_ready = vecs[i].mr;
            sb.push_back('{idx: i, st: vecs[i].st,
                           ctl: ref_ctl(vecs[i].st, vecs[i].mr, vecs[i].iop, vecs[i].ill),
                           ret: vecs[i].ret});
            #1;
            e = sb.pop_front();
            check($sformatf("row%0d_state", e.idx), 64'(state), 64'(e.st));
            check($sformatf("row%0d_ctl", e.idx), 64'(act), 64'(e.ctl));
            check($sformatf("row%0d_retired", e.idx), 64'(retired), 64'(e.ret));
            check($sformatf("row%0d_state_w4", e.idx), 64'(state4), 64'(e.st));
            check($sformatf("row%0d_ctl_w4", e.idx), 64'(act4), 64'(e.ctl));
            check($sformatf("row%0d_retired_w4", e.idx), 64'(retired4), 64'(e.ret[3:0]));
        end

        // LW: 3 wait cycles in MEMREAD, 8 cycles FETCH through MEMWB
        cyc = 0; mrd = 0; waits = 0; done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            rst_n = 1; opcode = 6'b100011;
            if (state == 4'(MEMREAD) && waits < 3) begin mem_ready = 0; waits++; end
            else mem_ready = 1;
            #1;
            cyc++;
            if (mem_read && iord) mrd++;
            if (state == 4'(MEMWB)) begin
                done = 1;
                check("lw_wb_mem_to_reg", 64'(mem_to_reg), 64'd1);
            end
        end
        check("lw_reached_memwb", 64'(done), 64'd1);
        check("lw_total_cycles", 64'(cyc), 64'd8);
        check("lw_memread_cycles", 64'(mrd), 64'd4);

        // Illegal opcode pulse: one cycle, no writes, counter unchanged
        ill_cnt = 0; bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            opcode = (k == 1) ? 6'b111111 : 6'b000000;
            mem_ready = (k == 0);
            #1;
            if (illegal_op) ill_cnt++;
            if (reg_write || mem_write) bad++;
        end
        check("illegal_pulse_cycles", 64'(ill_cnt), 64'd1);
        check("illegal_no_writes", 64'(bad), 64'd0);
        check("illegal_back_to_fetch", 64'(state), 64'(FETCH));
        check("illegal_retired_kept", 64'(retired), 64'd17);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
